// File: rtl/scan_pkg.sv
// Shared definitions for the scan select controller: channel count and FSM state encodings.
package scan_pkg;

    localparam int NCH = 4;
    localparam int SW  = $clog2(NCH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/next_chan_pick.sv
// Combinational channel picker: next enabled channel in cyclic order after sel,
// a wrap flag when that search passes channel 0, and the lowest enabled channel.
module next_chan_pick
    import scan_pkg::*;
(
    input  logic [SW-1:0]  sel,
    input  logic [NCH-1:0] mask,
    output logic [SW-1:0]  next_sel,
    output logic           wrap,
    output logic [SW-1:0]  first_sel
);

    logic [SW-1:0] idx;

    always_comb begin
        next_sel  = sel;
        first_sel = '0;
        idx       = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) first_sel = SW'(i);
        end
        // Search from farthest to nearest so the closest set bit wins; d=NCH is sel itself.
        for (int d = NCH; d >= 1; d--) begin
            idx = sel + SW'(d);
            if (mask[idx]) next_sel = idx;
        end
        wrap = (next_sel <= sel);
    end

endmodule

// File: rtl/scan_select_ctrl.sv
// Scan controller driving a 2-to-4 decoder's select and active-low enable.
// Define SCAN_BLANK_EN to blank the decoder for BLANK cycles at each slot start.
module scan_select_ctrl
    import scan_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int BLANK = 8,
    parameter int CW    = $clog2(DIV)
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [NCH-1:0] mask,
    output logic [SW-1:0]  sel,
    output logic           en_n,
    output logic           frame_done
);

    if (DIV < 2) begin : g_div_chk
        $error("scan_select_ctrl: DIV must be at least 2");
    end

`ifdef SCAN_BLANK_EN
    if (BLANK < 1 || BLANK >= DIV) begin : g_blank_chk
        $error("scan_select_ctrl: BLANK must satisfy 1 <= BLANK < DIV");
    end
    localparam state_t        SLOT_START = S_BLANK;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
`else
    localparam state_t        SLOT_START = S_DRIVE;
`endif
    localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [SW-1:0] sel_nx, next_sel, first_sel;
    logic          wrap, fd_nx, en_n_nx;

    next_chan_pick u_pick (
        .sel       (sel),
        .mask      (mask),
        .next_sel  (next_sel),
        .wrap      (wrap),
        .first_sel (first_sel)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        sel_nx   = sel;
        fd_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (run && mask != '0) begin
                    sel_nx   = first_sel;
                    state_nx = SLOT_START;
                end
            end
`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                if (!run) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nx = S_DRIVE;
                end
            end
`endif
            S_DRIVE: begin
                if (!run) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == SLOT_LAST) begin
                    // Slot boundary: mask is sampled here and only here while running.
                    cnt_nx = '0;
                    if (mask == '0) begin
                        state_nx = S_IDLE;
                    end else begin
                        sel_nx   = next_sel;
                        fd_nx    = wrap;
                        state_nx = SLOT_START;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
        en_n_nx = (state_nx != S_DRIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel        <= '0;
            en_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sel        <= sel_nx;
            en_n       <= en_n_nx;
            frame_done <= fd_nx;
        end
    end

endmodule

// File: tb/tb_scan_select_ctrl.sv
// Self-checking bench for scan_select_ctrl: directed scenarios plus random run/mask traffic
// compared cycle by cycle against a slot-position reference model.
module tb_scan_select_ctrl;

    localparam int DIV = 10;
`ifdef SCAN_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en_n;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;

    // Reference model: is a scan active, position within the slot, current channel, pulse.
    bit m_active;
    int m_pos;
    int m_ch;
    bit m_fd;

    scan_select_ctrl #(.DIV(DIV), .BLANK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mask       (mask),
        .sel        (sel),
        .en_n       (en_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [3:0] m);
        for (int c = 0; c < 4; c++) if (m[c]) return c;
        return 0;
    endfunction

    function automatic int next_ch(input int cur, input logic [3:0] m);
        for (int d = 1; d <= 4; d++) if (m[(cur + d) % 4]) return (cur + d) % 4;
        return cur;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_pos    = 0;
        m_ch     = 0;
        m_fd     = 0;
    endtask

    task automatic model_step();
        int nc;
        m_fd = 0;
        if (!m_active) begin
            if (run && mask != 4'd0) begin
                m_active = 1;
                m_pos    = 0;
                m_ch     = lowest(mask);
            end
        end else if (!run) begin
            m_active = 0;
        end else if (m_pos == DIV - 1) begin
            m_pos = 0;
            if (mask == 4'd0) begin
                m_active = 0;
            end else begin
                nc   = next_ch(m_ch, mask);
                m_fd = (nc <= m_ch);
                m_ch = nc;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check("sel", 8'(sel), 8'(m_ch));
            check("en_n", 8'(en_n), 8'(!(m_active && m_pos >= BL)));
            check("frame_done", 8'(frame_done), 8'(m_fd));
            if (frame_done) fd_seen++;
        end
    endtask

    initial begin
        rst  = 1'b1;
        run  = 1'b0;
        mask = 4'd0;
        model_reset();
        #2;
        check("reset_sel", 8'(sel), 8'd0);
        check("reset_en_n", 8'(en_n), 8'd1);
        check("reset_frame_done", 8'(frame_done), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(3);

        // Full mask: two frames in 81 cycles starting at the IDLE exit.
        mask = 4'b1111; run = 1'b1; fd_seen = 0;
        cycle(81);
        check("fd_count_1111", 8'(fd_seen), 8'd2);
        run = 1'b0;
        cycle(2);

        // Alternating channels, then a mid-slot switch to a single channel.
        mask = 4'b1010; run = 1'b1; fd_seen = 0;
        cycle(41);
        check("fd_count_1010", 8'(fd_seen), 8'd2);
        cycle(5);
        mask = 4'b0100;
        cycle(40);
        run = 1'b0;
        cycle(2);

        // Drop run in the middle of DRIVE, then restart on a new mask.
        mask = 4'b1111; run = 1'b1;
        cycle(7);
        run = 1'b0;
        cycle(1);
        check("drop_en_n", 8'(en_n), 8'd1);
        mask = 4'b0110; run = 1'b1;
        cycle(1);
        check("restart_sel", 8'(sel), 8'd1);
        cycle(15);

        // Empty mask keeps the controller idle.
        mask = 4'b0000; fd_seen = 0;
        cycle(25);
        check("empty_mask_fd", 8'(fd_seen), 8'd0);
        check("empty_mask_en_n", 8'(en_n), 8'd1);

        for (int s = 0; s < 300; s++) begin
            mask = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run  = ($urandom_range(0, 9) != 0);
            cycle($urandom_range(1, 25));
        end

        // Asynchronous reset mid-scan, away from any clock edge.
        mask = 4'b1111; run = 1'b1;
        cycle(13);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sel", 8'(sel), 8'd0);
        check("async_rst_en_n", 8'(en_n), 8'd1);
        check("async_rst_frame_done", 8'(frame_done), 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
